lt24_qsys_ocimem_debug_arbiter: RTL and testbench

- Shares the Nios II on-chip debug memory (OCI RAM, single port, 1-cycle read latency) between two requesters.
- Requester 1: the JTAG debug slave's sysclk-side action pulses (address-load, read, write).
- Requester 2: the CPU's Avalon-MM debug slave port.
- Provides round-robin arbitration, JTAG address auto-increment, the MonDReg data register and monitor_ready/monitor_error status. Sits between the JTAG debug slave sysclk logic and the OCI RAM.

---
 rtl/lt24_qsys_ocimem_pkg.sv | 33 +++
 rtl/lt24_qsys_ocimem_jtag_req.sv | 112 +++++++++++
 rtl/lt24_qsys_ocimem_debug_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_lt24_qsys_ocimem_debug_arbiter.sv | 522 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lt24_qsys_ocimem_pkg.sv
// ----------------------------------------------------------------------------
// lt24_qsys_ocimem_pkg
// Shared types for the OCI debug-memory arbiter slice:
//   state_e - arbiter FSM states
//   grant_e - requester identity, used for round-robin bookkeeping
//   req_e   - type of a pending JTAG request
// ----------------------------------------------------------------------------
package lt24_qsys_ocimem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CPU_RD,
        JTAG_RD
    } state_e;

    typedef enum logic {
        GNT_CPU,
        GNT_JTAG
    } grant_e;

    typedef enum logic {
        REQ_RD,
        REQ_WR
    } req_e;

    // Address comparison done at 32 bits so any ADDR_W / limit pair compares
    // without truncating the limit.
    function automatic logic addr_below(input logic [31:0] addr,
                                        input logic [31:0] limit);
        return addr < limit;
    endfunction

endpackage

// File: rtl/lt24_qsys_ocimem_jtag_req.sv
// ----------------------------------------------------------------------------
// lt24_qsys_ocimem_jtag_req
// JTAG front end: address counter, single-entry pending-request latch,
// monitor_ready / sticky monitor_error status.
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   load_i, addr_i           load the address counter
//   rd_i, wr_i, wdata_i      one-cycle request pulses and write data
//   err_clr_i                clear the sticky error
//   done_i                   arbiter finished the pending request
//   prot_err_i               arbiter suppressed a protected JTAG write
//   ptr_o                    current JTAG word address
//   pend_o, type_o, wdata_o  pending request and its payload
//   ready_o, error_o         monitor_ready / monitor_error
// ----------------------------------------------------------------------------
module lt24_qsys_ocimem_jtag_req
    import lt24_qsys_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              err_clr_i,
    input  logic              done_i,
    input  logic              prot_err_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              pend_o,
    output req_e              type_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              ready_o,
    output logic              error_o
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              pend_q, pend_d;
    req_e              type_q, type_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;

    logic req_any, req_both, accept, load_ok, err_set;

    assign req_any  = rd_i | wr_i;
    assign req_both = rd_i & wr_i;
    // Anything arriving while a request is outstanding is a protocol error.
    assign accept   = req_any & ~req_both & ~pend_q;
    assign load_ok  = load_i & ~pend_q;
    assign err_set  = (pend_q & (req_any | load_i)) | req_both | prot_err_i;

    always_comb begin
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        type_d  = type_q;
        wdata_d = wdata_q;
        ready_d = ready_q;
        error_d = error_q;

        // done_i only occurs while pend_q=1, so it never overlaps load_ok/accept.
        if (done_i) begin
            pend_d  = 1'b0;
            ready_d = 1'b1;
            ptr_d   = ptr_q + ADDR_W'(1);
        end
        if (load_ok) begin
            ptr_d = addr_i;
        end
        if (accept) begin
            pend_d  = 1'b1;
            ready_d = 1'b0;
            type_d  = wr_i ? REQ_WR : REQ_RD;
            wdata_d = wdata_i;
        end

        if (err_set) begin
            error_d = 1'b1;
        end else if (err_clr_i) begin
            error_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q   <= '0;
            pend_q  <= 1'b0;
            type_q  <= REQ_RD;
            wdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            type_q  <= type_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign ptr_o   = ptr_q;
    assign pend_o  = pend_q;
    assign type_o  = type_q;
    assign wdata_o = wdata_q;
    assign ready_o = ready_q;
    assign error_o = error_q;

endmodule

// File: rtl/lt24_qsys_ocimem_debug_arbiter.sv
// ----------------------------------------------------------------------------
// lt24_qsys_ocimem_debug_arbiter
// Round-robin sharing of the single-port OCI debug RAM (1-cycle read latency)
// between the JTAG debug slave (sysclk-side pulses) and the CPU Avalon-MM
// debug slave.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   jtag_addr_load/jtag_addr           load JTAG address counter
//   jtag_rd/jtag_wr/jtag_wdata         JTAG request pulses
//   jtag_err_clr                       clear monitor_error
//   MonDReg, monitor_ready, monitor_error  JTAG-side results/status
//   cpu_read/cpu_write/cpu_address/cpu_writedata/cpu_byteenable,
//   cpu_readdata/cpu_waitrequest       Avalon-MM slave
//   ram_addr/ram_we/ram_be/ram_wdata/ram_rdata  OCI RAM port
// Build option:
//   LT24_QSYS_OCIMEM_ROM_PROTECT_EN - suppress writes below ROM_WORDS; a
//   suppressed JTAG write flags monitor_error, a CPU one is dropped silently.
// ----------------------------------------------------------------------------
module lt24_qsys_ocimem_debug_arbiter
    import lt24_qsys_ocimem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int ROM_WORDS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                jtag_addr_load,
    input  logic [ADDR_W-1:0]   jtag_addr,
    input  logic                jtag_rd,
    input  logic                jtag_wr,
    input  logic [DATA_W-1:0]   jtag_wdata,
    input  logic                jtag_err_clr,
    output logic [DATA_W-1:0]   MonDReg,
    output logic                monitor_ready,
    output logic                monitor_error,
    input  logic                cpu_read,
    input  logic                cpu_write,
    input  logic [ADDR_W-1:0]   cpu_address,
    input  logic [DATA_W-1:0]   cpu_writedata,
    input  logic [DATA_W/8-1:0] cpu_byteenable,
    output logic [DATA_W-1:0]   cpu_readdata,
    output logic                cpu_waitrequest,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_we,
    output logic [DATA_W/8-1:0] ram_be,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

`ifdef LT24_QSYS_OCIMEM_ROM_PROTECT_EN
    localparam logic ROM_PROTECT = 1'b1;
`else
    localparam logic ROM_PROTECT = 1'b0;
`endif

    state_e            state_q;
    grant_e            last_q;
    logic [DATA_W-1:0] mondreg_q;

    logic [ADDR_W-1:0] jtag_ptr;
    logic              jtag_pend;
    req_e              jtag_type;
    logic [DATA_W-1:0] jtag_wdata_q;
    logic              jtag_done;
    logic              jtag_prot_err;

    logic   cpu_req;
    logic   gnt_valid;
    grant_e gnt;
    logic   cpu_in_rom, jtag_in_rom;
    logic   jtag_wr_gnt;

    assign cpu_req     = cpu_read | cpu_write;
    assign cpu_in_rom  = ROM_PROTECT & addr_below(32'(cpu_address), 32'(ROM_WORDS));
    assign jtag_in_rom = ROM_PROTECT & addr_below(32'(jtag_ptr), 32'(ROM_WORDS));

    // Grant is decided from the live CPU request so that a request withdrawn
    // before being granted leaves no trace on the RAM port.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = GNT_CPU;
        if (!reset && state_q == IDLE) begin
            if (cpu_req && jtag_pend) begin
                gnt_valid = 1'b1;
                gnt       = (last_q == GNT_CPU) ? GNT_JTAG : GNT_CPU;
            end else if (jtag_pend) begin
                gnt_valid = 1'b1;
                gnt       = GNT_JTAG;
            end else if (cpu_req) begin
                gnt_valid = 1'b1;
                gnt       = GNT_CPU;
            end
        end
    end

    assign jtag_wr_gnt   = gnt_valid && gnt == GNT_JTAG && jtag_type == REQ_WR;
    assign jtag_done     = jtag_wr_gnt || (!reset && state_q == JTAG_RD);
    assign jtag_prot_err = jtag_wr_gnt && jtag_in_rom;

    always_comb begin
        ram_addr        = '0;
        ram_we          = 1'b0;
        ram_be          = '0;
        ram_wdata       = '0;
        cpu_waitrequest = 1'b1;
        cpu_readdata    = '0;

        if (gnt_valid && gnt == GNT_CPU) begin
            ram_addr = cpu_address;
            ram_be   = cpu_byteenable;
            if (cpu_write) begin
                ram_we          = ~cpu_in_rom;
                ram_wdata       = cpu_writedata;
                cpu_waitrequest = 1'b0;
            end
        end
        if (gnt_valid && gnt == GNT_JTAG) begin
            ram_addr = jtag_ptr;
            if (jtag_type == REQ_WR) begin
                ram_we    = ~jtag_in_rom;
                ram_be    = '1;
                ram_wdata = jtag_wdata_q;
            end
        end
        if (!reset && state_q == CPU_RD) begin
            cpu_waitrequest = 1'b0;
            cpu_readdata    = ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= GNT_CPU;
            mondreg_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        last_q <= gnt;
                        if (gnt == GNT_CPU && !cpu_write) begin
                            state_q <= CPU_RD;
                        end else if (gnt == GNT_JTAG && jtag_type == REQ_RD) begin
                            state_q <= JTAG_RD;
                        end
                    end
                end
                CPU_RD: begin
                    state_q <= IDLE;
                end
                JTAG_RD: begin
                    mondreg_q <= ram_rdata;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    lt24_qsys_ocimem_jtag_req #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_jtag_req (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (jtag_addr_load),
        .addr_i     (jtag_addr),
        .rd_i       (jtag_rd),
        .wr_i       (jtag_wr),
        .wdata_i    (jtag_wdata),
        .err_clr_i  (jtag_err_clr),
        .done_i     (jtag_done),
        .prot_err_i (jtag_prot_err),
        .ptr_o      (jtag_ptr),
        .pend_o     (jtag_pend),
        .type_o     (jtag_type),
        .wdata_o    (jtag_wdata_q),
        .ready_o    (monitor_ready),
        .error_o    (monitor_error)
    );

    assign MonDReg = mondreg_q;

endmodule

// File: tb/tb_lt24_qsys_ocimem_debug_arbiter.sv
// ----------------------------------------------------------------------------
// tb_lt24_qsys_ocimem_debug_arbiter
// Bench for the OCI debug-memory arbiter. A behavioural single-port RAM with
// 1-cycle read latency sits on the RAM port; ref_mem holds the contents the
// RAM should have according to the transactions the bench has issued.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_lt24_qsys_ocimem_debug_arbiter;

`ifdef LT24_QSYS_OCIMEM_ROM_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  localparam logic [7:0] OFS = PROT ? 8'h80 : 8'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic        jtag_addr_load, jtag_rd, jtag_wr, jtag_err_clr;
  logic [7:0]  jtag_addr;
  logic [31:0] jtag_wdata;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic        cpu_read, cpu_write;
  logic [7:0]  cpu_address;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  lt24_qsys_ocimem_debug_arbiter #(
    .ADDR_W(8),
    .DATA_W(32),
    .ROM_WORDS(64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .jtag_addr_load (jtag_addr_load),
    .jtag_addr      (jtag_addr),
    .jtag_rd        (jtag_rd),
    .jtag_wr        (jtag_wr),
    .jtag_wdata     (jtag_wdata),
    .jtag_err_clr   (jtag_err_clr),
    .MonDReg        (MonDReg),
    .monitor_ready  (monitor_ready),
    .monitor_error  (monitor_error),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_address    (cpu_address),
    .cpu_writedata  (cpu_writedata),
    .cpu_byteenable (cpu_byteenable),
    .cpu_readdata   (cpu_readdata),
    .cpu_waitrequest(cpu_waitrequest),
    .ram_addr       (ram_addr),
    .ram_we         (ram_we),
    .ram_be         (ram_be),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r = (r & ~(32'hFF << (8 * b))) | (nw & (32'hFF << (8 * b)));
    end
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    jtag_addr_load = 1'b0; jtag_rd = 1'b0; jtag_wr = 1'b0; jtag_err_clr = 1'b0;
    jtag_addr = '0; jtag_wdata = '0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0;
    cpu_writedata = '0; cpu_byteenable = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic jtag_pulse(input logic ld, input logic [7:0] a, input logic r,
                            input logic w, input logic [31:0] d, input logic clr);
    jtag_addr_load = ld; jtag_addr = a; jtag_rd = r; jtag_wr = w;
    jtag_wdata = d; jtag_err_clr = clr;
    @(posedge clk);
    #1;
    jtag_addr_load = 1'b0; jtag_rd = 1'b0; jtag_wr = 1'b0; jtag_err_clr = 1'b0;
  endtask

  task automatic jtag_wait_ready(output logic ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      @(negedge clk);
      if (monitor_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] rd,
                          output logic ok, output logic we_seen);
    cpu_read = ~wr; cpu_write = wr; cpu_address = a;
    cpu_writedata = d; cpu_byteenable = be;
    ok = 1'b0; rd = '0; we_seen = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_waitrequest) begin
        rd = cpu_readdata; we_seen = ram_we; ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic cpu_wr_ref(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic ok, we;
    cpu_xfer(1'b1, a, d, 4'hF, rd, ok, we);
    ref_mem[a] = d;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1; cpu_write = 1'b1; cpu_address = 8'hE0;
    cpu_writedata = '1; cpu_byteenable = '1; jtag_wr = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ram_we, cpu_waitrequest} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_no_write: we/wait=%b expected 01", {ram_we, cpu_waitrequest});
    end
    @(posedge clk); #1;
    cpu_write = 1'b0; jtag_wr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (MonDReg !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mondreg: got %h expected 00000000", MonDReg);
    end
    n_cmp++;
    if ({monitor_ready, monitor_error, cpu_waitrequest, ram_we, cpu_readdata} !== {4'b0010, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_status: rdy/err/wait/we=%b rdata=%h expected 0010/0",
               {monitor_ready, monitor_error, cpu_waitrequest, ram_we}, cpu_readdata);
    end
    @(negedge clk);
    n_cmp++;
    if (ram_we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pend_cleared: ram_we=%b expected 0", ram_we);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_jtag_write();
    logic [7:0] a;
    a = OFS + 8'h10;
    jtag_pulse(1'b1, a, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({ram_we, ram_addr, ram_be, ram_wdata} !== {1'b1, a, 4'hF, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL jtag_wr_port: we=%b addr=%h be=%h wd=%h expected 1 %h f deadbeef",
               ram_we, ram_addr, ram_be, ram_wdata, a);
    end
    n_cmp++;
    if (monitor_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL jtag_wr_busy: ready=%b expected 0", monitor_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({monitor_ready, ram_we} !== 2'b10) begin
      n_bad++;
      $display("FAIL jtag_wr_ready: ready/we=%b expected 10", {monitor_ready, ram_we});
    end
    ref_mem[a] = 32'hDEADBEEF;
    @(posedge clk); #1;
  endtask

  task automatic test_jtag_read();
    logic [7:0] a;
    a = OFS + 8'h11;
    cpu_wr_ref(a, 32'h12345678);
    jtag_pulse(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({ram_addr, monitor_ready} !== {a, 1'b0}) begin
      n_bad++;
      $display("FAIL jtag_rd_addr: addr=%h ready=%b expected %h 0", ram_addr, monitor_ready, a);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({MonDReg, monitor_ready} !== {ref_mem[a], 1'b1}) begin
      n_bad++;
      $display("FAIL jtag_rd_data: MonDReg=%h ready=%b expected %h 1",
               MonDReg, monitor_ready, ref_mem[a]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tie();
    logic ok;
    logic [7:0] a20, a21, a30, a31;
    a20 = OFS + 8'h20; a21 = OFS + 8'h21; a30 = OFS + 8'h30; a31 = OFS + 8'h31;
    cpu_wr_ref(a20, 32'hA0A0_2020);
    cpu_wr_ref(a21, 32'hA1A1_2121);
    cpu_wr_ref(a30, 32'hB0B0_3030);
    cpu_wr_ref(a31, 32'hB1B1_3131);
    do_reset();
    jtag_pulse(1'b1, a30, 1'b1, 1'b0, 32'h0, 1'b0);
    cpu_read = 1'b1; cpu_address = a20; cpu_byteenable = 4'hF;
    @(negedge clk);
    n_cmp++;
    if ({ram_addr, cpu_waitrequest} !== {a30, 1'b1}) begin
      n_bad++;
      $display("FAIL tie1_jtag_first: addr=%h wait=%b expected %h 1", ram_addr, cpu_waitrequest, a30);
    end
    @(negedge clk);
    n_cmp++;
    if (cpu_waitrequest !== 1'b1) begin
      n_bad++;
      $display("FAIL tie1_cpu_waits: wait=%b expected 1", cpu_waitrequest);
    end
    @(negedge clk);
    n_cmp++;
    if ({ram_addr, cpu_waitrequest} !== {a20, 1'b1}) begin
      n_bad++;
      $display("FAIL tie1_cpu_grant: addr=%h wait=%b expected %h 1", ram_addr, cpu_waitrequest, a20);
    end
    @(negedge clk);
    n_cmp++;
    if ({cpu_waitrequest, cpu_readdata} !== {1'b0, ref_mem[a20]}) begin
      n_bad++;
      $display("FAIL tie1_cpu_data: wait=%b rdata=%h expected 0 %h",
               cpu_waitrequest, cpu_readdata, ref_mem[a20]);
    end
    @(posedge clk); #1;
    cpu_read = 1'b0;
    n_cmp++;
    if (MonDReg !== ref_mem[a30]) begin
      n_bad++;
      $display("FAIL tie1_mondreg: got %h expected %h", MonDReg, ref_mem[a30]);
    end
    jtag_pulse(1'b1, OFS + 8'h40, 1'b0, 1'b1, 32'h4040_4040, 1'b0);
    jtag_wait_ready(ok);
    ref_mem[OFS + 8'h40] = 32'h4040_4040;
    jtag_pulse(1'b1, a31, 1'b1, 1'b0, 32'h0, 1'b0);
    cpu_read = 1'b1; cpu_address = a21;
    @(negedge clk);
    n_cmp++;
    if ({ram_addr, cpu_waitrequest} !== {a21, 1'b1}) begin
      n_bad++;
      $display("FAIL tie2_cpu_first: addr=%h wait=%b expected %h 1", ram_addr, cpu_waitrequest, a21);
    end
    @(negedge clk);
    n_cmp++;
    if ({cpu_waitrequest, cpu_readdata} !== {1'b0, ref_mem[a21]}) begin
      n_bad++;
      $display("FAIL tie2_cpu_data: wait=%b rdata=%h expected 0 %h",
               cpu_waitrequest, cpu_readdata, ref_mem[a21]);
    end
    @(posedge clk); #1;
    cpu_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ram_addr !== a31) begin
      n_bad++;
      $display("FAIL tie2_jtag_second: addr=%h expected %h", ram_addr, a31);
    end
    jtag_wait_ready(ok);
    n_cmp++;
    if ({ok, MonDReg} !== {1'b1, ref_mem[a31]}) begin
      n_bad++;
      $display("FAIL tie2_mondreg: ok=%b MonDReg=%h expected 1 %h", ok, MonDReg, ref_mem[a31]);
    end
  endtask

  task automatic test_wrap();
    logic ok;
    cpu_wr_ref(8'hFF, 32'hCAFEF00D);
    jtag_pulse(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    jtag_pulse(1'b1, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (ram_addr !== 8'hFF) begin
      n_bad++;
      $display("FAIL wrap_addr_ff: addr=%h expected ff", ram_addr);
    end
    jtag_wait_ready(ok);
    n_cmp++;
    if ({ok, MonDReg} !== {1'b1, 32'hCAFEF00D}) begin
      n_bad++;
      $display("FAIL wrap_data: ok=%b MonDReg=%h expected 1 cafef00d", ok, MonDReg);
    end
    jtag_pulse(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (ram_addr !== 8'h00) begin
      n_bad++;
      $display("FAIL wrap_addr_00: addr=%h expected 00", ram_addr);
    end
    jtag_wait_ready(ok);
    n_cmp++;
    if ({ok, monitor_error} !== 2'b10) begin
      n_bad++;
      $display("FAIL wrap_no_error: ok/err=%b expected 10", {ok, monitor_error});
    end
  endtask

  task automatic test_error();
    logic [7:0] a;
    a = OFS + 8'h50;
    jtag_pulse(1'b1, a, 1'b0, 1'b1, 32'h0BADF00D, 1'b0);
    jtag_pulse(1'b0, 8'h00, 1'b0, 1'b1, 32'hFFFF0000, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({monitor_error, monitor_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL err_busy_wr: err/ready=%b expected 11", {monitor_error, monitor_ready});
    end
    repeat (3) @(negedge clk);
    ref_mem[a] = 32'h0BADF00D;
    n_cmp++;
    if (mem[a] !== 32'h0BADF00D) begin
      n_bad++;
      $display("FAIL err_busy_ignored: mem=%h expected 0badf00d", mem[a]);
    end
    @(posedge clk); #1;
    jtag_pulse(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (monitor_error !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear: err=%b expected 0", monitor_error);
    end
    @(posedge clk); #1;
    jtag_pulse(1'b0, 8'h00, 1'b1, 1'b1, 32'h0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({monitor_error, monitor_ready, ram_we} !== 3'b110) begin
      n_bad++;
      $display("FAIL err_rdwr_set_wins: err/ready/we=%b expected 110",
               {monitor_error, monitor_ready, ram_we});
    end
    @(posedge clk); #1;
    jtag_pulse(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_rom();
    logic [31:0] rd;
    logic ok, we;
    cpu_xfer(1'b1, 8'h05, 32'hA5A5A5A5, 4'hF, rd, ok, we);
    n_cmp++;
    if ({ok, we} !== {1'b1, ~PROT}) begin
      n_bad++;
      $display("FAIL rom_cpu_write: done/we=%b expected %b", {ok, we}, {1'b1, ~PROT});
    end
    jtag_pulse(1'b1, 8'h05, 1'b0, 1'b1, 32'h5A5A5A5A, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({ram_we, ram_addr} !== {~PROT, 8'h05}) begin
      n_bad++;
      $display("FAIL rom_jtag_port: we=%b addr=%h expected %b 05", ram_we, ram_addr, ~PROT);
    end
    jtag_wait_ready(ok);
    n_cmp++;
    if ({ok, monitor_error} !== {1'b1, PROT}) begin
      n_bad++;
      $display("FAIL rom_jtag_err: ready/err=%b expected %b", {ok, monitor_error}, {1'b1, PROT});
    end
    jtag_pulse(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] rd, d;
    logic [7:0]  a;
    logic [3:0]  be;
    logic ok, we;
    int op;
    for (int unsigned i = 0; i < 32; i++) cpu_wr_ref(8'hC0 + 8'(i), $urandom);
    for (int unsigned i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      a  = 8'hC0 + 8'($urandom_range(0, 31));
      d  = $urandom;
      case (op)
        0: begin
          be = 4'($urandom_range(1, 15));
          cpu_xfer(1'b1, a, d, be, rd, ok, we);
          ref_mem[a] = merge(ref_mem[a], d, be);
          n_cmp++;
          if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL rnd_cpu_wr_timeout: addr=%h", a);
          end
        end
        1: begin
          cpu_xfer(1'b0, a, 32'h0, 4'hF, rd, ok, we);
          n_cmp++;
          if ({ok, rd} !== {1'b1, ref_mem[a]}) begin
            n_bad++;
            $display("FAIL rnd_cpu_rd: addr=%h ok=%b got %h expected %h", a, ok, rd, ref_mem[a]);
          end
        end
        2: begin
          jtag_pulse(1'b1, a, 1'b0, 1'b1, d, 1'b0);
          jtag_wait_ready(ok);
          ref_mem[a] = d;
          n_cmp++;
          if ({ok, monitor_error} !== 2'b10) begin
            n_bad++;
            $display("FAIL rnd_jtag_wr: addr=%h ready/err=%b expected 10", a, {ok, monitor_error});
          end
        end
        default: begin
          jtag_pulse(1'b1, a, 1'b1, 1'b0, 32'h0, 1'b0);
          jtag_wait_ready(ok);
          n_cmp++;
          if ({ok, MonDReg} !== {1'b1, ref_mem[a]}) begin
            n_bad++;
            $display("FAIL rnd_jtag_rd: addr=%h ok=%b got %h expected %h", a, ok, MonDReg, ref_mem[a]);
          end
        end
      endcase
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic ok1, ok2, we;
    for (int unsigned i = 0; i < 6; i++) begin
      fork
        begin
          jtag_pulse(1'b1, 8'hC0 + 8'(2 * i), 1'b1, 1'b0, 32'h0, 1'b0);
          jtag_wait_ready(ok1);
        end
        begin
          cpu_xfer(1'b0, 8'hC1 + 8'(2 * i), 32'h0, 4'hF, rd, ok2, we);
        end
      join
      n_cmp++;
      if ({ok1, ok2, MonDReg, rd} !== {2'b11, ref_mem[8'hC0 + 8'(2 * i)], ref_mem[8'hC1 + 8'(2 * i)]}) begin
        n_bad++;
        $display("FAIL b2b_%0d: ok=%b%b MonDReg=%h cpu=%h expected 11 %h %h", i, ok1, ok2,
                 MonDReg, rd, ref_mem[8'hC0 + 8'(2 * i)], ref_mem[8'hC1 + 8'(2 * i)]);
      end
    end
  endtask

  task automatic test_cpu_drop();
    logic ok;
    cpu_wr_ref(8'hE8, 32'h1111_2222);
    do_reset();
    jtag_pulse(1'b1, 8'hC3, 1'b1, 1'b0, 32'h0, 1'b0);
    cpu_write = 1'b1; cpu_address = 8'hE8; cpu_writedata = 32'hDEAD0000; cpu_byteenable = 4'hF;
    @(negedge clk);
    n_cmp++;
    if ({cpu_waitrequest, ram_we} !== 2'b10) begin
      n_bad++;
      $display("FAIL drop_wait: wait/we=%b expected 10", {cpu_waitrequest, ram_we});
    end
    @(posedge clk); #1;
    cpu_write = 1'b0;
    jtag_wait_ready(ok);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ok, mem[8'hE8], MonDReg} !== {1'b1, ref_mem[8'hE8], ref_mem[8'hC3]}) begin
      n_bad++;
      $display("FAIL drop_no_effect: ok=%b mem=%h MonDReg=%h expected 1 %h %h",
               ok, mem[8'hE8], MonDReg, ref_mem[8'hE8], ref_mem[8'hC3]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_jtag_write();
    test_jtag_read();
    test_tie();
    test_wrap();
    test_error();
    test_rom();
    test_random();
    test_back_to_back();
    test_cpu_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
